// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin scheduler that feeds one requester word at a
// time, MSB first, through a shared serial Mealy pattern matcher. After the
// whole word has been shifted it reports the match count and the position of
// the first match, then returns to arbitration.
module seq_scan_arbiter #(
  parameter int                 N_REQ   = 4,
  parameter int                 WIDTH   = 8,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
  localparam int                IDW     = $clog2(N_REQ),
  localparam int                CW      = $clog2(WIDTH + 1),
  localparam int                PW      = $clog2(WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic                   z,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [CW-1:0]          match_count,
  output logic                   match_found,
  output logic [PW-1:0]          first_pos
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  // First bit index at which a full pattern window exists, and last bit index.
  localparam logic [PW-1:0] K_FIRST = PW'(PAT_LEN - 1);
  localparam logic [PW-1:0] K_LAST  = PW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [IDW-1:0]       last_q;
  logic [IDW-1:0]       gid_q;
  logic [WIDTH-1:0]     shreg_q;
  logic [PAT_LEN-2:0]   hist_q;
  logic [PW-1:0]        bit_q;
  logic [CW-1:0]        cnt_q;
  logic                 found_q;
  logic [PW-1:0]        fpos_q;

  logic [WIDTH-1:0]     words [N_REQ];
  logic                 grant_valid;
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       cand;
  logic                 x;
  logic [PAT_LEN-1:0]   window;
  logic                 last_bit;
  logic [CW-1:0]        cnt_next;
  logic                 found_next;
  logic [PW-1:0]        fpos_next;

  // Unpack the flat requester bus into per-requester words.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign words[gi] = data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDW'((int'(last_q) + i) % N_REQ);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Mealy matcher: window is the history plus the bit being processed now.
  always_comb begin
    x          = shreg_q[WIDTH-1];
    window     = {hist_q, x};
    last_bit   = (bit_q == K_LAST);
    z          = (state_q == S_SHIFT) && (bit_q >= K_FIRST) && (window == PATTERN);
    cnt_next   = z ? cnt_q + CW'(1) : cnt_q;
    found_next = found_q | z;
    fpos_next  = (z && !found_q) ? bit_q : fpos_q;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: arbitrate only in IDLE, shift WIDTH bits, report once.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (grant_valid) state_d = S_SHIFT;
      S_SHIFT:  if (last_bit)    state_d = S_REPORT;
      S_REPORT:                  state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_REPORT);

  // Datapath: grant latch, shift register, match accumulators, result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q      <= IDW'(N_REQ - 1);
      gid_q       <= '0;
      shreg_q     <= '0;
      hist_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      fpos_q      <= '0;
      ack         <= '0;
      done_id     <= '0;
      match_count <= '0;
      match_found <= 1'b0;
      first_pos   <= '0;
    end else begin
      ack <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            ack[grant_idx] <= 1'b1;
            last_q         <= grant_idx;
            gid_q          <= grant_idx;
            shreg_q        <= words[grant_idx];
            hist_q         <= '0;
            bit_q          <= '0;
            cnt_q          <= '0;
            found_q        <= 1'b0;
            fpos_q         <= '0;
          end
        end
        S_SHIFT: begin
          shreg_q <= shreg_q << 1;
          hist_q  <= window[PAT_LEN-2:0];
          bit_q   <= bit_q + PW'(1);
          cnt_q   <= cnt_next;
          found_q <= found_next;
          fpos_q  <= fpos_next;
          // Publish the results on the edge entering REPORT so they are valid with done.
          if (last_bit) begin
            done_id     <= gid_q;
            match_count <= cnt_next;
            match_found <= found_next;
            first_pos   <= fpos_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Testbench for seq_scan_arbiter: directed requests with hand-computed
// results queued as expectations; a monitor checks ack, the z strobe pattern,
// done timing and the reported result against the queue.
module tb_seq_scan_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic [N_REQ-1:0] ack;
    logic [1:0]       id;
    logic [WIDTH-1:0] zmask;
    logic [3:0]       count;
    logic             found;
    logic [2:0]       fpos;
  } exp_t;

  logic                   clock;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic                   z;
  logic                   done;
  logic [1:0]             done_id;
  logic [3:0]             match_count;
  logic                   match_found;
  logic [2:0]             first_pos;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   ack_cycles[$];

  // Monitor state.
  logic             inflight = 1'b0;
  int               mon_k    = 0;
  logic [WIDTH-1:0] mon_z    = '0;

  seq_scan_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .busy        (busy),
    .z           (z),
    .done        (done),
    .done_id     (done_id),
    .match_count (match_count),
    .match_found (match_found),
    .first_pos   (first_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_word(input int id, input logic [WIDTH-1:0] zmask,
                             input logic [3:0] cnt, input logic [2:0] fpos);
    exp_t e;
    e.ack   = '0;
    e.ack[id] = 1'b1;
    e.id    = 2'(id);
    e.zmask = zmask;
    e.count = cnt;
    e.found = (cnt != 0);
    e.fpos  = fpos;
    exp_q.push_back(e);
  endtask

  task automatic set_word(input int id, input logic [WIDTH-1:0] w);
    data[id*WIDTH +: WIDTH] = w;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ack"},         32'(ack), 0);
    check({tag, "_busy"},        32'(busy), 0);
    check({tag, "_z"},           32'(z), 0);
    check({tag, "_done"},        32'(done), 0);
    check({tag, "_done_id"},     32'(done_id), 0);
    check({tag, "_match_count"}, 32'(match_count), 0);
    check({tag, "_match_found"}, 32'(match_found), 0);
    check({tag, "_first_pos"},   32'(first_pos), 0);
  endtask

  // Run until every requester has been acked and every result reported.
  task automatic drain(input int budget);
    int n = 0;
    while ((req != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
      if (ack != 0) begin
        ack_cycles.push_back(cyc);
        req = req & ~ack;
      end
    end
    check("drain_pending_results", 32'(exp_q.size()), 0);
    check("drain_pending_req", 32'(req), 0);
  endtask

  // Monitor: on ack start tracking a word, collect z per bit, expect done after WIDTH cycles.
  always @(negedge clock) begin
    if (!reset) begin
      inflight = 1'b0;
    end else begin
      if (ack != 0) begin
        if (inflight) check("ack_while_busy", 32'(ack), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 0);
        end else begin
          check("ack_onehot", 32'(ack), 32'(exp_q[0].ack));
          check("busy_in_shift", 32'(busy), 1);
          inflight = 1'b1;
          mon_k    = 0;
          mon_z    = '0;
        end
      end
      if (inflight) begin
        if (mon_k < WIDTH) begin
          mon_z[mon_k] = z;
          if (done) check("done_early", 32'(done), 0);
          mon_k++;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_strobe",  32'(done), 1);
          check("z_pattern",    32'(mon_z), 32'(e.zmask));
          check("done_id",      32'(done_id), 32'(e.id));
          check("match_count",  32'(match_count), 32'(e.count));
          check("match_found",  32'(match_found), 32'(e.found));
          check("first_pos",    32'(first_pos), 32'(e.fpos));
          check("ack_not_with_done", 32'(ack), 0);
          inflight = 1'b0;
        end
      end else if (done) begin
        check("unexpected_done", 32'(done), 0);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0;
    req   = '0;
    data  = '0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b1;
    @(negedge clock);

    // Basic: 0110_0110 matches at k=3 and k=7.
    set_word(0, 8'b0110_0110);
    expect_word(0, 8'h88, 4'd2, 3'd3);
    req = 4'b0001;
    drain(40);

    // Overlap: 0110_1100 matches at k=3 and k=6.
    set_word(0, 8'b0110_1100);
    expect_word(0, 8'h48, 4'd2, 3'd3);
    req = 4'b0001;
    drain(40);

    // No match.
    set_word(0, 8'hFF);
    expect_word(0, 8'h00, 4'd0, 3'd0);
    req = 4'b0001;
    drain(40);

    // Window completes 0110 at k=2 only with cleared history; must not count.
    set_word(0, 8'b1100_0000);
    expect_word(0, 8'h00, 4'd0, 3'd0);
    req = 4'b0001;
    drain(40);

    // Fresh reset so requester 0 wins first, then all four in RR order.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    set_word(0, 8'h00);
    set_word(1, 8'h06);
    set_word(2, 8'hB6);
    set_word(3, 8'h6D);
    expect_word(0, 8'h00, 4'd0, 3'd0);
    expect_word(1, 8'h80, 4'd1, 3'd7);
    expect_word(2, 8'h90, 4'd2, 3'd4);
    expect_word(3, 8'h48, 4'd2, 3'd3);
    ack_cycles.delete();
    req = 4'b1111;
    drain(100);
    check("fair_ack_total", 32'(ack_cycles.size()), 4);
    for (int i = 1; i < ack_cycles.size(); i++)
      check("fair_ack_spacing", 32'(ack_cycles[i] - ack_cycles[i-1]), WIDTH + 2);

    // Pointer at 3: serve requester 2, then 0 and 2 together -> 0 before 2.
    set_word(2, 8'h66);
    expect_word(2, 8'h88, 4'd2, 3'd3);
    req = 4'b0100;
    drain(40);
    set_word(0, 8'h06);
    set_word(2, 8'hB6);
    expect_word(0, 8'h80, 4'd1, 3'd7);
    expect_word(2, 8'h90, 4'd2, 3'd4);
    req = 4'b0101;
    drain(60);

    // Abort mid-SHIFT at k=4 after one match has already been counted.
    set_word(2, 8'h66);
    expect_word(2, 8'h88, 4'd2, 3'd3);
    req = 4'b0100;
    n = 0;
    while (ack == 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("abort_ack_seen", 32'(ack), 32'(4'b0100));
    req = '0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1 check_cleared("abort");
    exp_q.delete();
    repeat (2) @(negedge clock);
    check("abort_no_done", 32'(done), 0);
    reset = 1'b1;
    @(negedge clock);

    // Requester 1 served with a fresh count.
    set_word(1, 8'b1100_0000);
    expect_word(1, 8'h00, 4'd0, 3'd0);
    req = 4'b0010;
    drain(40);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
